// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode, ALU-op and control-word definitions for the pipeline control unit.
package pipe_ctrl_pkg;

  localparam int unsigned OP_RTYPE = 0;
  localparam int unsigned OP_LW    = 35;
  localparam int unsigned OP_SW    = 43;
  localparam int unsigned OP_BEQ   = 4;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [1:0] {
    FwdRegfile = 2'b00,
    FwdWb      = 2'b01,
    FwdMem     = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // The younger producer (EX/MEM) wins over MEM/WB.
  function automatic fwd_sel_t fwd_select(input logic mem_hit, input logic wb_hit);
    if (mem_hit) begin
      return FwdMem;
    end else if (wb_hit) begin
      return FwdWb;
    end
    return FwdRegfile;
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational ID-stage decoder: opcode to control word, illegal flag and rt-usage flag.
module ctrl_decoder
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6
) (
  input  logic                valid_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  output ctrl_t               ctrl_o,
  output logic                illegal_o,
  output logic                uses_rt_o
);

  always_comb begin
    ctrl_o    = CTRL_NOP;
    illegal_o = 1'b0;
    uses_rt_o = 1'b0;
    if (valid_i) begin
      case (opcode_i)
        OPCODE_W'(OP_RTYPE): begin
          ctrl_o.reg_dst   = 1'b1;
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_op    = ALUOP_FUNCT;
          uses_rt_o        = 1'b1;
        end
        OPCODE_W'(OP_LW): begin
          ctrl_o.alu_src    = 1'b1;
          ctrl_o.mem_read   = 1'b1;
          ctrl_o.mem_to_reg = 1'b1;
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.alu_op     = ALUOP_ADD;
        end
        OPCODE_W'(OP_SW): begin
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.mem_write = 1'b1;
          ctrl_o.alu_op    = ALUOP_ADD;
          uses_rt_o        = 1'b1;
        end
        OPCODE_W'(OP_BEQ): begin
          ctrl_o.branch = 1'b1;
          ctrl_o.alu_op = ALUOP_SUB;
          uses_rt_o     = 1'b1;
        end
        default: illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control registers (ID/EX, EX/MEM, MEM/WB) with forwarding, load-use stall and
// branch-flush logic for the 5-stage core.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W          = 6,
  parameter int unsigned REG_ADDR_W        = 5,
  parameter bit          SW_FWD_EN         = 1'b1,
  parameter bit          LOAD_USE_STALL_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [OPCODE_W-1:0]   id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  mem_zero,
  output logic                  stall,
  output logic                  flush,
  output logic                  illegal_op,
  output logic                  ex_alu_src,
  output logic                  ex_mem_read,
  output logic [1:0]            ex_alu_op,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_sw_fwd,
  output logic                  branch_taken,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_write_reg
);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  ctrl_t     id_ctrl;
  logic      id_uses_rt;
  reg_addr_t id_dst;

  ctrl_t     idex_ctrl_d, idex_ctrl_q;
  reg_addr_t idex_rs_d, idex_rs_q, idex_rt_d, idex_rt_q, idex_dst_d, idex_dst_q;
  ctrl_t     exmem_ctrl_d, exmem_ctrl_q;
  reg_addr_t exmem_rt_d, exmem_rt_q, exmem_dst_d, exmem_dst_q;
  ctrl_t     wb_ctrl_d, wb_ctrl_q;
  reg_addr_t wb_dst_d, wb_dst_q;

  logic load_use;
  logic mem_hit_a, wb_hit_a, mem_hit_b, wb_hit_b;

  ctrl_decoder #(
    .OPCODE_W (OPCODE_W)
  ) u_decoder (
    .valid_i   (id_valid),
    .opcode_i  (id_opcode),
    .ctrl_o    (id_ctrl),
    .illegal_o (illegal_op),
    .uses_rt_o (id_uses_rt)
  );

  assign id_dst = id_ctrl.reg_dst ? id_rd : id_rt;

  always_comb begin
    load_use = idex_ctrl_q.mem_read && (idex_dst_q != '0) &&
               ((idex_dst_q == id_rs) || (id_uses_rt && (idex_dst_q == id_rt)));
    branch_taken = exmem_ctrl_q.branch && mem_zero;
    flush        = branch_taken;
    // A taken branch squashes the consumer anyway, so it suppresses the stall.
    stall        = LOAD_USE_STALL_EN && load_use && !branch_taken;
  end

  always_comb begin
    idex_ctrl_d  = id_ctrl;
    idex_rs_d    = id_rs;
    idex_rt_d    = id_rt;
    idex_dst_d   = id_dst;
    exmem_ctrl_d = idex_ctrl_q;
    exmem_rt_d   = idex_rt_q;
    exmem_dst_d  = idex_dst_q;
    wb_ctrl_d    = exmem_ctrl_q;
    wb_dst_d     = exmem_dst_q;
    if (stall || flush) begin
      idex_ctrl_d = CTRL_NOP;
      idex_rs_d   = '0;
      idex_rt_d   = '0;
      idex_dst_d  = '0;
    end
    if (flush) begin
      exmem_ctrl_d = CTRL_NOP;
      exmem_rt_d   = '0;
      exmem_dst_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_ctrl_q  <= CTRL_NOP;
      idex_rs_q    <= '0;
      idex_rt_q    <= '0;
      idex_dst_q   <= '0;
      exmem_ctrl_q <= CTRL_NOP;
      exmem_rt_q   <= '0;
      exmem_dst_q  <= '0;
      wb_ctrl_q    <= CTRL_NOP;
      wb_dst_q     <= '0;
    end else begin
      idex_ctrl_q  <= idex_ctrl_d;
      idex_rs_q    <= idex_rs_d;
      idex_rt_q    <= idex_rt_d;
      idex_dst_q   <= idex_dst_d;
      exmem_ctrl_q <= exmem_ctrl_d;
      exmem_rt_q   <= exmem_rt_d;
      exmem_dst_q  <= exmem_dst_d;
      wb_ctrl_q    <= wb_ctrl_d;
      wb_dst_q     <= wb_dst_d;
    end
  end

  always_comb begin
    mem_hit_a = exmem_ctrl_q.reg_write && (exmem_dst_q != '0) && (exmem_dst_q == idex_rs_q);
    mem_hit_b = exmem_ctrl_q.reg_write && (exmem_dst_q != '0) && (exmem_dst_q == idex_rt_q);
    wb_hit_a  = wb_ctrl_q.reg_write && (wb_dst_q != '0) && (wb_dst_q == idex_rs_q);
    wb_hit_b  = wb_ctrl_q.reg_write && (wb_dst_q != '0) && (wb_dst_q == idex_rt_q);
    fwd_a     = fwd_select(mem_hit_a, wb_hit_a);
    fwd_b     = fwd_select(mem_hit_b, wb_hit_b);
    mem_sw_fwd = SW_FWD_EN && exmem_ctrl_q.mem_write && wb_ctrl_q.reg_write &&
                 (wb_dst_q != '0) && (wb_dst_q == exmem_rt_q);
  end

  assign ex_alu_src    = idex_ctrl_q.alu_src;
  assign ex_mem_read   = idex_ctrl_q.mem_read;
  assign ex_alu_op     = idex_ctrl_q.alu_op;
  assign mem_read      = exmem_ctrl_q.mem_read;
  assign mem_write     = exmem_ctrl_q.mem_write;
  assign wb_reg_write  = wb_ctrl_q.reg_write;
  assign wb_mem_to_reg = wb_ctrl_q.mem_to_reg;
  assign wb_write_reg  = wb_dst_q;

  // Later stages carry the full control word but only consume a few of its fields.
  logic unused_ctrl;
  assign unused_ctrl = ^{exmem_ctrl_q, wb_ctrl_q};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a second instance has store forwarding and stalls disabled.
module tb_pipe_hazard_ctrl;

  localparam logic [5:0] OpR   = 6'd0;
  localparam logic [5:0] OpLw  = 6'd35;
  localparam logic [5:0] OpSw  = 6'd43;
  localparam logic [5:0] OpBeq = 6'd4;
  localparam logic [5:0] OpBad = 6'd63;

  logic clk, rst_n, id_valid, mem_zero;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, id_rd;

  logic stall, flush, illegal_op, ex_alu_src, ex_mem_read, mem_read, mem_write;
  logic mem_sw_fwd, branch_taken, wb_reg_write, wb_mem_to_reg;
  logic [1:0] ex_alu_op, fwd_a, fwd_b;
  logic [4:0] wb_write_reg;

  logic u1_stall, u1_flush, u1_illegal_op, u1_ex_alu_src, u1_ex_mem_read, u1_mem_read;
  logic u1_mem_write, u1_mem_sw_fwd, u1_branch_taken, u1_wb_reg_write, u1_wb_mem_to_reg;
  logic [1:0] u1_ex_alu_op, u1_fwd_a, u1_fwd_b;
  logic [4:0] u1_wb_write_reg;

  logic [21:0] all_outs;
  assign all_outs = {stall, flush, illegal_op, ex_alu_src, ex_mem_read, ex_alu_op, fwd_a, fwd_b,
                     mem_read, mem_write, mem_sw_fwd, branch_taken, wb_reg_write, wb_mem_to_reg,
                     wb_write_reg};

  int n_checks;
  int n_fail;

  pipe_hazard_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd), .mem_zero(mem_zero), .stall(stall), .flush(flush),
    .illegal_op(illegal_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
    .ex_alu_op(ex_alu_op), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_read(mem_read),
    .mem_write(mem_write), .mem_sw_fwd(mem_sw_fwd), .branch_taken(branch_taken),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_write_reg(wb_write_reg)
  );

  pipe_hazard_ctrl #(
    .SW_FWD_EN(1'b0), .LOAD_USE_STALL_EN(1'b0)
  ) u_dut_nofwd (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd), .mem_zero(mem_zero), .stall(u1_stall), .flush(u1_flush),
    .illegal_op(u1_illegal_op), .ex_alu_src(u1_ex_alu_src), .ex_mem_read(u1_ex_mem_read),
    .ex_alu_op(u1_ex_alu_op), .fwd_a(u1_fwd_a), .fwd_b(u1_fwd_b), .mem_read(u1_mem_read),
    .mem_write(u1_mem_write), .mem_sw_fwd(u1_mem_sw_fwd), .branch_taken(u1_branch_taken),
    .wb_reg_write(u1_wb_reg_write), .wb_mem_to_reg(u1_wb_mem_to_reg),
    .wb_write_reg(u1_wb_write_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_id(input logic v, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd);
    id_valid  = v;
    id_opcode = op;
    id_rs     = rs;
    id_rt     = rt;
    id_rd     = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (all_outs !== '0) begin n_fail++; $display("FAIL reset_outs got=%h exp=0", all_outs); end
    #2 rst_n = 1'b1;
    #1;
    n_checks++; if (all_outs !== '0) begin n_fail++; $display("FAIL release_outs got=%h exp=0", all_outs); end
    tick();
    set_id(1'b1, OpLw, 5'd2, 5'd4, 5'd0);
    tick();
    set_id(1'b1, OpR, 5'd1, 5'd1, 5'd7);
    tick();
    n_checks++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL pre_rst_mem_read got=%b exp=1", mem_read); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (all_outs !== '0) begin n_fail++; $display("FAIL midrun_rst_outs got=%h exp=0", all_outs); end
    set_id(1'b1, OpLw, 5'd2, 5'd4, 5'd0);
    #1 rst_n = 1'b1;
    #1;
    n_checks++; if (all_outs !== '0) begin n_fail++; $display("FAIL first_cycle_outs got=%h exp=0", all_outs); end
    tick();
    n_checks++; if (ex_mem_read !== 1'b1) begin n_fail++; $display("FAIL lw_edge1 got=%b exp=1", ex_mem_read); end
    set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
    tick();
    n_checks++; if (wb_mem_to_reg !== 1'b0) begin n_fail++; $display("FAIL lw_edge2_wb got=%b exp=0", wb_mem_to_reg); end
    tick();
    n_checks++; if (wb_mem_to_reg !== 1'b1) begin n_fail++; $display("FAIL lw_edge3_wb got=%b exp=1", wb_mem_to_reg); end
    n_checks++; if (wb_write_reg !== 5'd4) begin n_fail++; $display("FAIL lw_edge3_dst got=%0d exp=4", wb_write_reg); end
  endtask

  task automatic test_reset_mid_stall();
    drain();
    set_id(1'b1, OpLw, 5'd1, 5'd8, 5'd0);
    tick();
    set_id(1'b1, OpR, 5'd8, 5'd10, 5'd9);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL pre_rst_stall got=%b exp=1", stall); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_kills_stall got=%b exp=0", stall); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (ex_alu_op !== 2'b10) begin n_fail++; $display("FAIL post_rst_add got=%b exp=10", ex_alu_op); end
  endtask

  task automatic test_load_use();
    drain();
    set_id(1'b1, OpLw, 5'd1, 5'd8, 5'd0);
    tick();
    set_id(1'b1, OpR, 5'd8, 5'd10, 5'd9);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got=%b exp=1", stall); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL lu_flush got=%b exp=0", flush); end
    tick();
    n_checks++; if ({ex_mem_read, ex_alu_op} !== 3'b000) begin n_fail++; $display("FAIL lu_bubble got=%b exp=000", {ex_mem_read, ex_alu_op}); end
    n_checks++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL lu_load_mem got=%b exp=1", mem_read); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_one_cycle got=%b exp=0", stall); end
    tick();
    n_checks++; if (fwd_a !== 2'b01) begin n_fail++; $display("FAIL lu_fwd_a got=%b exp=01", fwd_a); end
    n_checks++; if (fwd_b !== 2'b00) begin n_fail++; $display("FAIL lu_fwd_b got=%b exp=00", fwd_b); end
    drain();
    set_id(1'b1, OpLw, 5'd1, 5'd8, 5'd0);
    tick();
    set_id(1'b1, OpLw, 5'd3, 5'd8, 5'd0);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_lw_rt_only got=%b exp=0", stall); end
    set_id(1'b1, OpSw, 5'd3, 5'd8, 5'd0);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_sw_rt got=%b exp=1", stall); end
    n_checks++; if (u1_stall !== 1'b0) begin n_fail++; $display("FAIL lu_disabled got=%b exp=0", u1_stall); end
    drain();
    set_id(1'b1, OpLw, 5'd1, 5'd0, 5'd0);
    tick();
    set_id(1'b1, OpR, 5'd0, 5'd0, 5'd5);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_reg0 got=%b exp=0", stall); end
  endtask

  task automatic test_forwarding();
    drain();
    set_id(1'b1, OpR, 5'd1, 5'd2, 5'd3);
    tick();
    set_id(1'b1, OpR, 5'd4, 5'd5, 5'd3);
    tick();
    set_id(1'b1, OpR, 5'd3, 5'd3, 5'd6);
    tick();
    n_checks++; if (fwd_a !== 2'b10) begin n_fail++; $display("FAIL dbl_fwd_a got=%b exp=10", fwd_a); end
    n_checks++; if (fwd_b !== 2'b10) begin n_fail++; $display("FAIL dbl_fwd_b got=%b exp=10", fwd_b); end
    drain();
    set_id(1'b1, OpR, 5'd1, 5'd2, 5'd0);
    tick();
    tick();
    set_id(1'b1, OpR, 5'd0, 5'd0, 5'd6);
    tick();
    n_checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_fail++; $display("FAIL reg0_fwd got=%b exp=0000", {fwd_a, fwd_b}); end
    drain();
    set_id(1'b1, OpR, 5'd1, 5'd2, 5'd3);
    tick();
    set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
    tick();
    set_id(1'b1, OpR, 5'd9, 5'd3, 5'd6);
    tick();
    n_checks++; if ({fwd_a, fwd_b} !== 4'b0001) begin n_fail++; $display("FAIL wb_fwd_b got=%b exp=0001", {fwd_a, fwd_b}); end
  endtask

  task automatic test_store_fwd();
    drain();
    set_id(1'b1, OpR, 5'd1, 5'd2, 5'd5);
    tick();
    set_id(1'b1, OpSw, 5'd3, 5'd5, 5'd0);
    tick();
    set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
    tick();
    n_checks++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL sw_mem_write got=%b exp=1", mem_write); end
    n_checks++; if (mem_sw_fwd !== 1'b1) begin n_fail++; $display("FAIL sw_fwd got=%b exp=1", mem_sw_fwd); end
    n_checks++; if (u1_mem_sw_fwd !== 1'b0) begin n_fail++; $display("FAIL sw_fwd_disabled got=%b exp=0", u1_mem_sw_fwd); end
    drain();
    set_id(1'b1, OpR, 5'd1, 5'd2, 5'd5);
    tick();
    set_id(1'b1, OpSw, 5'd3, 5'd6, 5'd0);
    tick();
    set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
    tick();
    n_checks++; if (mem_sw_fwd !== 1'b0) begin n_fail++; $display("FAIL sw_fwd_other_reg got=%b exp=0", mem_sw_fwd); end
    drain();
    set_id(1'b1, OpR, 5'd1, 5'd2, 5'd0);
    tick();
    set_id(1'b1, OpSw, 5'd3, 5'd0, 5'd0);
    tick();
    set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
    tick();
    n_checks++; if (mem_sw_fwd !== 1'b0) begin n_fail++; $display("FAIL sw_fwd_reg0 got=%b exp=0", mem_sw_fwd); end
    drain();
    set_id(1'b1, OpLw, 5'd1, 5'd5, 5'd0);
    tick();
    set_id(1'b1, OpSw, 5'd2, 5'd5, 5'd0);
    tick();
    set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
    tick();
    n_checks++; if ({u1_mem_write, u1_wb_mem_to_reg, u1_mem_sw_fwd} !== 3'b110) begin n_fail++; $display("FAIL lw_sw_disabled got=%b exp=110", {u1_mem_write, u1_wb_mem_to_reg, u1_mem_sw_fwd}); end
  endtask

  task automatic test_branch();
    drain();
    set_id(1'b1, OpBeq, 5'd1, 5'd2, 5'd0);
    tick();
    set_id(1'b1, OpLw, 5'd1, 5'd8, 5'd0);
    tick();
    set_id(1'b1, OpR, 5'd8, 5'd10, 5'd9);
    mem_zero = 1'b0;
    #1;
    n_checks++; if ({branch_taken, stall} !== 2'b01) begin n_fail++; $display("FAIL br_not_taken got=%b exp=01", {branch_taken, stall}); end
    mem_zero = 1'b1;
    #1;
    n_checks++; if ({branch_taken, flush, stall} !== 3'b110) begin n_fail++; $display("FAIL br_taken got=%b exp=110", {branch_taken, flush, stall}); end
    tick();
    mem_zero = 1'b0;
    #1;
    n_checks++; if ({ex_alu_src, ex_mem_read, ex_alu_op} !== 4'b0000) begin n_fail++; $display("FAIL br_ex_nop got=%b exp=0000", {ex_alu_src, ex_mem_read, ex_alu_op}); end
    n_checks++; if ({mem_read, mem_write, flush} !== 3'b000) begin n_fail++; $display("FAIL br_mem_nop got=%b exp=000", {mem_read, mem_write, flush}); end
  endtask

  task automatic test_illegal();
    drain();
    set_id(1'b1, OpBad, 5'd1, 5'd7, 5'd7);
    #1;
    n_checks++; if (illegal_op !== 1'b1) begin n_fail++; $display("FAIL illegal_valid got=%b exp=1", illegal_op); end
    set_id(1'b0, OpBad, 5'd1, 5'd7, 5'd7);
    #1;
    n_checks++; if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL illegal_invalid got=%b exp=0", illegal_op); end
    set_id(1'b1, OpBad, 5'd1, 5'd7, 5'd7);
    tick();
    set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
    #1;
    n_checks++; if ({ex_alu_src, ex_mem_read, ex_alu_op} !== 4'b0000) begin n_fail++; $display("FAIL illegal_ex_nop got=%b exp=0000", {ex_alu_src, ex_mem_read, ex_alu_op}); end
    tick();
    tick();
    n_checks++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL illegal_wb got=%b exp=0", wb_reg_write); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    mem_zero = 1'b0;
    set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
    test_reset();
    test_reset_mid_stall();
    test_load_use();
    test_forwarding();
    test_store_fwd();
    test_branch();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
